// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI scheduler: FSM state encoding and data width helper.
// Optional BUSY watchdog is enabled by defining SPI_SCHED_TIMEOUT_EN.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  function automatic int data_w(input int width_log);
    return 1 << width_log;
  endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Rotating-priority pick: first asserted request at or after ptr, wrapping.
// Purely combinational; returns one-hot grant, its index and an any flag.
module spi_rr_arb
  import spi_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_sched.sv
// Round-robin scheduler sharing one SPI master among N_REQ requesters.
// Define SPI_SCHED_TIMEOUT_EN to add a BUSY watchdog that reports rsp_err.
module spi_sched
  import spi_sched_pkg::*;
#(
  parameter  int N_REQ             = 4,
  parameter  int SPI_MAX_WIDTH_LOG = 4,
  parameter  int GAP_CYCLES        = 4,
  parameter  int TIMEOUT_CYCLES    = 4096,
  localparam int DATA_W            = data_w(SPI_MAX_WIDTH_LOG),
  localparam int IW                = $clog2(N_REQ),
  localparam int SW                = SPI_MAX_WIDTH_LOG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_cpol,
  input  logic [N_REQ-1:0]      req_cpha,
  input  logic [N_REQ*SW-1:0]   req_width,
  input  logic [N_REQ*DATA_W-1:0] req_tx_data,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rx_data,
  output logic                  spi_start,
  output logic                  spi_cpol,
  output logic                  spi_cpha,
  output logic [SW-1:0]         spi_width,
  output logic [DATA_W-1:0]     spi_tx_data,
  input  logic                  spi_finish,
  input  logic [DATA_W-1:0]     spi_rx_data,
  output logic [N_REQ-1:0]      spi_cs_sel
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t            state, state_nx;
  logic [IW-1:0]     rr, owner, win_idx;
  logic [N_REQ-1:0]  win_oh, owner_oh;
  logic              win_any;
  logic [GW-1:0]     gap_cnt;
  logic              cpol_q, cpha_q;
  logic [SW-1:0]     width_q;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic              tmo_hit;

  spi_rr_arb #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  assign owner_oh = N_REQ'(1) << owner;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_START) tmo_cnt <= '0;
      else if (state == S_BUSY) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == S_IDLE) err_q <= 1'b0;
      else if (state == S_BUSY && !spi_finish && tmo_hit) err_q <= 1'b1;
    end
  end

  assign rsp_err = (state == S_DONE) && err_q;
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (win_any) state_nx = S_START;
      S_START: state_nx = S_BUSY;
      S_BUSY:  if (spi_finish || tmo_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_GAP;
      S_GAP:   if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    spi_start  = 1'b0;
    spi_cs_sel = '0;
    unique case (1'b1)
      state == S_START: begin
        req_ready  = owner_oh;
        spi_start  = 1'b1;
        spi_cs_sel = owner_oh;
      end
      state == S_BUSY: spi_cs_sel = owner_oh;
      state == S_DONE: rsp_valid  = owner_oh;
      default: ;
    endcase
  end

  // Winner's fields are latched so the requester may change them after ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= '0;
      owner   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      width_q <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == S_IDLE && win_any) begin
        owner   <= win_idx;
        rr      <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
        cpol_q  <= req_cpol[win_idx];
        cpha_q  <= req_cpha[win_idx];
        width_q <= req_width[win_idx*SW +: SW];
        tx_q    <= req_tx_data[win_idx*DATA_W +: DATA_W];
      end
      if (state == S_BUSY) begin
        if (spi_finish)   rx_q <= spi_rx_data;
        else if (tmo_hit) rx_q <= '0;
      end
      if (state == S_DONE)     gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + GW'(1);
    end
  end

  assign spi_cpol    = cpol_q;
  assign spi_cpha    = cpha_q;
  assign spi_width   = width_q;
  assign spi_tx_data = tx_q;
  assign rsp_rx_data = rx_q;

endmodule

// File: tb/tb_spi_sched.sv
// Directed testbench for spi_sched: reset, single transfer, round robin,
// wrap, mode latching, mid-transfer reset and (if enabled) the watchdog.
module tb_spi_sched;

  localparam int N   = 4;
  localparam int WL  = 4;
  localparam int DW  = 16;
  localparam int GAP = 4;
  localparam int TMO = 4096;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_cpol;
  logic [N-1:0]    req_cpha;
  logic [N*WL-1:0] req_width;
  logic [N*DW-1:0] req_tx_data;
  logic [N-1:0]    rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rx_data;
  logic            spi_start;
  logic            spi_cpol;
  logic            spi_cpha;
  logic [WL-1:0]   spi_width;
  logic [DW-1:0]   spi_tx_data;
  logic            spi_finish;
  logic [DW-1:0]   spi_rx_data;
  logic [N-1:0]    spi_cs_sel;

  int checks   = 0;
  int failures = 0;

  spi_sched #(
    .N_REQ(N), .SPI_MAX_WIDTH_LOG(WL),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cpol(req_cpol), .req_cpha(req_cpha),
    .req_width(req_width), .req_tx_data(req_tx_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rx_data(rsp_rx_data), .spi_start(spi_start),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_width(spi_width), .spi_tx_data(spi_tx_data),
    .spi_finish(spi_finish), .spi_rx_data(spi_rx_data),
    .spi_cs_sel(spi_cs_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic reset_dut;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_cpol    = '0;
    req_cpha    = '0;
    req_width   = '0;
    req_tx_data = '0;
    spi_finish  = 1'b0;
    spi_rx_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for spi_start, then finishes after busy cycles; ends at DONE.
  task automatic do_txn(input int busy, input logic [DW-1:0] rx,
                        output int owner, output int gap, output bit ok);
    ok = 1'b0; gap = 0; owner = -1;
    for (int c = 0; c < 100; c++) begin
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
      if (spi_cs_sel == '0) gap++;
      @(negedge clk);
    end
    if (!ok) return;
    for (int i = 0; i < N; i++) if (spi_cs_sel[i]) owner = i;
    @(negedge clk);
    repeat (busy) @(negedge clk);
    spi_finish  = 1'b1;
    spi_rx_data = rx;
    @(negedge clk);
    spi_finish  = 1'b0;
    spi_rx_data = '0;
  endtask

  task automatic test_reset;
    logic [63:0] outs;
    rst_n = 1'b0;
    req_valid = '0; req_cpol = '0; req_cpha = '0;
    req_width = '0; req_tx_data = '0;
    spi_finish = 1'b0; spi_rx_data = '0;
    #1;
    outs = {req_ready, rsp_valid, rsp_err, spi_start, spi_cs_sel,
            spi_cpol, spi_cpha, spi_width, spi_tx_data, rsp_rx_data};
    checks++;
    if (outs !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    reset_dut();
    checks++;
    if (spi_start !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_idle got=%b/%b exp=0/0", spi_start, req_ready);
    end
  endtask

  task automatic test_single;
    reset_dut();
    req_width[3:0]    = 4'd7;
    req_tx_data[15:0] = 16'h00A5;
    req_valid         = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    checks++;
    if (spi_start !== 1'b1) begin
      failures++; $display("FAIL single_start got=%b exp=1", spi_start);
    end
    checks++;
    if (spi_cs_sel !== 4'b0001) begin
      failures++; $display("FAIL single_cs got=%b exp=0001", spi_cs_sel);
    end
    checks++;
    if (spi_width !== 4'd7 || spi_tx_data !== 16'h00A5) begin
      failures++;
      $display("FAIL single_latch got=%0d/%h exp=7/00a5", spi_width, spi_tx_data);
    end
    req_valid         = 4'b0000;
    req_tx_data[15:0] = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b0 || req_ready !== 4'b0000 || spi_cs_sel !== 4'b0001) begin
      failures++;
      $display("FAIL single_busy got=%b/%b/%b exp=0/0000/0001",
               spi_start, req_ready, spi_cs_sel);
    end
    repeat (19) @(negedge clk);
    spi_finish  = 1'b1;
    spi_rx_data = 16'h005A;
    @(negedge clk);
    spi_finish  = 1'b0;
    spi_rx_data = '0;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_rx_data !== 16'h005A || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got=%b/%h/%b exp=0001/005a/0",
               rsp_valid, rsp_rx_data, rsp_err);
    end
    checks++;
    if (spi_tx_data !== 16'h00A5 || spi_cs_sel !== 4'b0000) begin
      failures++;
      $display("FAIL single_done_hold got=%h/%b exp=00a5/0000", spi_tx_data, spi_cs_sel);
    end
    @(negedge clk);
    spi_finish  = 1'b1;
    spi_rx_data = 16'hFFFF;
    @(negedge clk);
    spi_finish  = 1'b0;
    spi_rx_data = '0;
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_rx_data !== 16'h005A || spi_cs_sel !== 4'b0000) begin
      failures++;
      $display("FAIL stray_finish_gap got=%b/%h/%b exp=0000/005a/0000",
               rsp_valid, rsp_rx_data, spi_cs_sel);
    end
  endtask

  task automatic test_back_to_back;
    int owner, gap;
    bit ok;
    reset_dut();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_txn(2, 16'h1000 + 16'(k), owner, gap, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL b2b_start_%0d got=none exp=start", k);
      end else if (owner != (k % 4)) begin
        failures++; $display("FAIL b2b_owner_%0d got=%0d exp=%0d", k, owner, k % 4);
      end
      if (k > 0) begin
        checks++;
        if (gap < GAP) begin
          failures++; $display("FAIL b2b_gap_%0d got=%0d exp>=%0d", k, gap, GAP);
        end
      end
      checks++;
      if (rsp_valid !== (4'b0001 << (k % 4)) || rsp_rx_data !== 16'h1000 + 16'(k)) begin
        failures++;
        $display("FAIL b2b_rsp_%0d got=%b/%h exp=%b/%h", k, rsp_valid,
                 rsp_rx_data, 4'b0001 << (k % 4), 16'h1000 + 16'(k));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_wrap;
    int owner, gap;
    bit ok;
    int exp_o[3] = '{2, 3, 0};
    reset_dut();
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      do_txn(1, 16'h2000, owner, gap, ok);
      if (k == 0) req_valid = 4'b1001;
      checks++;
      if (!ok || owner != exp_o[k]) begin
        failures++;
        $display("FAIL wrap_owner_%0d got=%0d exp=%0d", k, owner, exp_o[k]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_mode;
    int owner, gap;
    bit ok;
    reset_dut();
    req_cpol  = 4'b0001;
    req_cpha  = 4'b0010;
    req_valid = 4'b0011;
    do_txn(3, 16'h3000, owner, gap, ok);
    checks++;
    if (!ok || owner != 0 || spi_cpol !== 1'b1 || spi_cpha !== 1'b0) begin
      failures++;
      $display("FAIL mode_req0 got=%0d/%b%b exp=0/10", owner, spi_cpol, spi_cpha);
    end
    req_valid = 4'b0010;
    req_cpol  = 4'b0000;
    @(negedge clk);
    checks++;
    if (spi_cpol !== 1'b1 || spi_cpha !== 1'b0) begin
      failures++;
      $display("FAIL mode_gap_hold got=%b%b exp=10", spi_cpol, spi_cpha);
    end
    do_txn(3, 16'h3001, owner, gap, ok);
    checks++;
    if (!ok || owner != 1 || spi_cpol !== 1'b0 || spi_cpha !== 1'b1) begin
      failures++;
      $display("FAIL mode_req1 got=%0d/%b%b exp=1/01", owner, spi_cpol, spi_cpha);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_busy;
    bit ok;
    bit bad;
    logic [63:0] outs;
    reset_dut();
    req_width[11:8]    = 4'd5;
    req_tx_data[47:32] = 16'hBEEF;
    req_valid          = 4'b0100;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!ok || spi_cs_sel !== 4'b0100) begin
      failures++; $display("FAIL rstbusy_cs got=%b exp=0100", spi_cs_sel);
    end
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    outs = {req_ready, rsp_valid, rsp_err, spi_start, spi_cs_sel,
            spi_cpol, spi_cpha, spi_width, spi_tx_data, rsp_rx_data};
    checks++;
    if (outs !== 64'h0) begin
      failures++; $display("FAIL rstbusy_outputs got=%h exp=0", outs);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    spi_finish = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      spi_finish = 1'b0;
      if (rsp_valid !== '0 || spi_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL rstbusy_no_rsp got=activity exp=idle");
    end
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    bit ok, bad;
    reset_dut();
    req_valid = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = '0;
    @(negedge clk);
    n = 0;
    while (ok && rsp_valid === '0 && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok || n != TMO) begin
      failures++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TMO);
    end
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rx_data !== 16'h0) begin
      failures++;
      $display("FAIL tmo_rsp got=%b/%b/%h exp=0010/1/0000", rsp_valid, rsp_err, rsp_rx_data);
    end
    @(negedge clk);
    spi_finish  = 1'b1;
    spi_rx_data = 16'h7777;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      spi_finish = 1'b0;
      if (rsp_valid !== '0 || rsp_rx_data !== 16'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL tmo_stray_finish got=activity exp=ignored");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_mode();
    test_reset_busy();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
